// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_ctrl arbiter: sequencer states, engine field widths
// and default timing parameters.
package i2c_pkg;

    localparam int I2C_AW = 7;
    localparam int REG_AW = 8;
    localparam int LEN_W  = 5;
    localparam int DAT_W  = 8;

    localparam int DIV_DEFAULT = 250;
    localparam int TMO_DEFAULT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_BUSY,
        ST_ABORT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr,
// wrapping around, returned as one-hot, index and an any-request flag.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_ctrl engine among NREQ requesters: round-robin capture, enable/strobe
// launch handshake, per-transaction watchdog and registered response back to the owner.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DIV  = DIV_DEFAULT,
    parameter int TMO  = TMO_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [I2C_AW*NREQ-1:0]   req_i2c_addr,
    input  logic [NREQ-1:0]          req_rdwr,
    input  logic [REG_AW*NREQ-1:0]   req_reg_addr,
    input  logic [LEN_W*NREQ-1:0]    req_len,
    input  logic [DAT_W*NREQ-1:0]    req_wrdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [DAT_W-1:0]         rsp_rddata,
    output logic                     rsp_nack,
    output logic                     rsp_timeout,
    output logic                     i2c_strobe,
    output logic                     i2c_enable,
    output logic [I2C_AW-1:0]        i2c_addr,
    output logic                     reg_rdwr,
    output logic [REG_AW-1:0]        reg_addr,
    output logic [LEN_W-1:0]         reg_len,
    output logic [DAT_W-1:0]         reg_wrdata,
    output logic                     ctrl_arst_n,
    input  logic                     reg_done,
    input  logic                     i2c_ack,
    input  logic [DAT_W-1:0]         reg_rddata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(DIV);
    localparam int TW = 16;

    state_t            state, state_nxt;
    logic [DW-1:0]     div_cnt;
    logic [TW-1:0]     wd_cnt;
    logic              abort_cnt;
    logic [PW-1:0]     ptr, win;
    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [I2C_AW-1:0] sel_addr;
    logic              sel_rdwr;
    logic [REG_AW-1:0] sel_reg;
    logic [LEN_W-1:0]  sel_len;
    logic [DAT_W-1:0]  sel_wrdata;
    logic              launched;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_addr   = '0;
        sel_rdwr   = 1'b0;
        sel_reg    = '0;
        sel_len    = '0;
        sel_wrdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                sel_addr   = req_i2c_addr[i*I2C_AW +: I2C_AW];
                sel_rdwr   = req_rdwr[i];
                sel_reg    = req_reg_addr[i*REG_AW +: REG_AW];
                sel_len    = req_len[i*LEN_W +: LEN_W];
                sel_wrdata = req_wrdata[i*DAT_W +: DAT_W];
            end
        end
    end

    // Free-running bit-tick; the registered pulse follows count 0 by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            i2c_strobe <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            i2c_strobe <= (div_cnt == '0);
        end
    end

    assign launched = i2c_strobe && i2c_enable;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // IDLE holds off while rsp_valid is up so the owner can drop req before the next pick.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!rsp_valid && pick_any) state_nxt = ST_LAUNCH;
            ST_LAUNCH: if (launched) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (reg_done)                   state_nxt = ST_RESP;
                else if (wd_cnt == TW'(TMO))    state_nxt = ST_ABORT;
            end
            ST_ABORT:  if (abort_cnt) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rddata  <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            i2c_enable  <= 1'b0;
            i2c_addr    <= '0;
            reg_rdwr    <= 1'b0;
            reg_addr    <= '0;
            reg_len     <= '0;
            reg_wrdata  <= '0;
            ctrl_arst_n <= 1'b1;
            ptr         <= '0;
            win         <= '0;
            wd_cnt      <= '0;
            abort_cnt   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (rsp_valid) begin
                        gnt <= '0;
                    end else if (pick_any) begin
                        gnt        <= pick_onehot;
                        win        <= pick_idx;
                        i2c_addr   <= sel_addr;
                        reg_rdwr   <= sel_rdwr;
                        reg_addr   <= sel_reg;
                        reg_len    <= (sel_len == '0) ? LEN_W'(1) : sel_len;
                        reg_wrdata <= sel_wrdata;
                        i2c_enable <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (launched) begin
                        i2c_enable <= 1'b0;
                        wd_cnt     <= '0;
                    end
                end
                ST_BUSY: begin
                    if (i2c_strobe) wd_cnt <= wd_cnt + 1'b1;
                    if (reg_done) begin
                        rsp_rddata  <= reg_rddata;
                        rsp_nack    <= i2c_ack;
                        rsp_timeout <= 1'b0;
                    end else if (wd_cnt == TW'(TMO)) begin
                        ctrl_arst_n <= 1'b0;
                        abort_cnt   <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    abort_cnt <= 1'b1;
                    if (abort_cnt) begin
                        ctrl_arst_n <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_nack    <= 1'b1;
                        rsp_rddata  <= '0;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    ptr       <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter (NREQ=3, DIV=4, TMO=20) with a behavioural i2c_ctrl engine model.
module tb_i2c_arbiter;
    import i2c_pkg::*;

    localparam int NREQ = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [I2C_AW*NREQ-1:0] req_i2c_addr = '0;
    logic [NREQ-1:0]        req_rdwr = '0;
    logic [REG_AW*NREQ-1:0] req_reg_addr = '0;
    logic [LEN_W*NREQ-1:0]  req_len = '0;
    logic [DAT_W*NREQ-1:0]  req_wrdata = '0;
    logic [NREQ-1:0]        gnt;
    logic                   rsp_valid, rsp_nack, rsp_timeout;
    logic [7:0]             rsp_rddata;
    logic                   i2c_strobe, i2c_enable, reg_rdwr, ctrl_arst_n;
    logic [6:0]             i2c_addr;
    logic [7:0]             reg_addr, reg_wrdata;
    logic [4:0]             reg_len;
    logic                   reg_done = 1'b0;
    logic                   i2c_ack = 1'b0;
    logic [7:0]             reg_rddata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.NREQ(NREQ), .DIV(4), .TMO(20)) dut (
        .clk(clk), .rst(rst), .req(req), .req_i2c_addr(req_i2c_addr), .req_rdwr(req_rdwr),
        .req_reg_addr(req_reg_addr), .req_len(req_len), .req_wrdata(req_wrdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .i2c_strobe(i2c_strobe), .i2c_enable(i2c_enable),
        .i2c_addr(i2c_addr), .reg_rdwr(reg_rdwr), .reg_addr(reg_addr), .reg_len(reg_len),
        .reg_wrdata(reg_wrdata), .ctrl_arst_n(ctrl_arst_n), .reg_done(reg_done),
        .i2c_ack(i2c_ack), .reg_rddata(reg_rddata)
    );

    // Engine model: starts on a strobe with enable high, finishes 6 strobes later;
    // reg_done stays high (stale) until the next start.
    logic       nack_mode = 1'b0;
    logic       hang_mode = 1'b0;
    logic [7:0] rd_value  = 8'h3C;
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic [6:0] m_addr = '0;
    logic       m_rdwr = 1'b0;
    logic [7:0] m_reg = '0;
    logic [4:0] m_len = '0;
    logic [7:0] m_wdata = '0;
    int         en_samples = 0;
    int         arst_lo = 0;
    int         rsp_count = 0;

    always @(posedge clk) begin
        if (rst || !ctrl_arst_n) begin
            m_busy   <= 1'b0;
            reg_done <= 1'b0;
        end else if (i2c_strobe && i2c_enable) begin
            m_busy   <= 1'b1;
            m_cnt    <= 0;
            reg_done <= 1'b0;
            m_addr   <= i2c_addr;
            m_rdwr   <= reg_rdwr;
            m_reg    <= reg_addr;
            m_len    <= reg_len;
            m_wdata  <= reg_wrdata;
        end else if (m_busy && i2c_strobe) begin
            if (!hang_mode && m_cnt == 5) begin
                m_busy     <= 1'b0;
                reg_done   <= 1'b1;
                i2c_ack    <= nack_mode;
                reg_rddata <= m_rdwr ? rd_value : 8'h00;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (i2c_strobe && i2c_enable) en_samples <= en_samples + 1;
        if (!ctrl_arst_n)             arst_lo    <= arst_lo + 1;
        if (rsp_valid)                rsp_count  <= rsp_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int r, input logic [6:0] a, input logic rw,
                            input logic [7:0] ra, input logic [4:0] len, input logic [7:0] wd);
        req_i2c_addr[r*I2C_AW +: I2C_AW] = a;
        req_rdwr[r]                      = rw;
        req_reg_addr[r*REG_AW +: REG_AW] = ra;
        req_len[r*LEN_W +: LEN_W]        = len;
        req_wrdata[r*DAT_W +: DAT_W]     = wd;
    endtask

    logic [2:0] r_gnt;
    logic [7:0] r_data;
    logic       r_nack, r_tmo;

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("rsp_wait_expired", 32'(k >= 1000), 32'(0));
        r_gnt  = gnt;
        r_data = rsp_rddata;
        r_nack = rsp_nack;
        r_tmo  = rsp_timeout;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] strobe_pat;
        int         base;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_enable", 32'(i2c_enable), 32'(0));
        check("rst_arst_n", 32'(ctrl_arst_n), 32'(1));
        check("rst_fields", 32'({i2c_addr, reg_addr, reg_len}), 32'(0));
        rst = 1'b0;

        // First strobe one clock after release, then every 4 clocks
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            strobe_pat[i] = i2c_strobe;
        end
        check("strobe_pattern", 32'(strobe_pat), 32'(5'b10001));

        // Single write from requester 1
        set_slot(1, 7'h50, 1'b0, 8'h10, 5'd2, 8'hA5);
        req[1] = 1'b1;
        base = en_samples;
        @(negedge clk);
        check("wr_gnt_latency", 32'(gnt), 32'(3'b010));
        check("wr_enable_up", 32'(i2c_enable), 32'(1));
        wait_rsp();
        req[1] = 1'b0;
        check("wr_rsp_gnt", 32'(r_gnt), 32'(3'b010));
        check("wr_rsp_nack", 32'(r_nack), 32'(0));
        check("wr_rsp_tmo", 32'(r_tmo), 32'(0));
        check("wr_enable_samples", 32'(en_samples - base), 32'(1));
        check("wr_engine_fields", 32'({m_addr, m_rdwr, m_reg, m_len, m_wdata}),
              32'({7'h50, 1'b0, 8'h10, 5'd2, 8'hA5}));

        // Read from requester 0, len 0 promoted to 1
        set_slot(0, 7'h21, 1'b1, 8'h33, 5'd0, 8'h00);
        rd_value = 8'h3C;
        req[0] = 1'b1;
        @(negedge clk);
        check("rd_reg_len", 32'(reg_len), 32'(1));
        wait_rsp();
        req[0] = 1'b0;
        check("rd_rsp_gnt", 32'(r_gnt), 32'(3'b001));
        check("rd_rddata", 32'(r_data), 32'(8'h3C));
        check("rd_nack", 32'(r_nack), 32'(0));
        check("rd_engine_len", 32'(m_len), 32'(1));

        // NACK from requester 2
        nack_mode = 1'b1;
        set_slot(2, 7'h11, 1'b0, 8'h02, 5'd1, 8'h77);
        req[2] = 1'b1;
        wait_rsp();
        req[2] = 1'b0;
        nack_mode = 1'b0;
        check("nack_gnt", 32'(r_gnt), 32'(3'b100));
        check("nack_flag", 32'(r_nack), 32'(1));
        check("nack_tmo", 32'(r_tmo), 32'(0));

        // Fairness from reset with all requests held
        do_reset();
        for (int r = 0; r < NREQ; r++) set_slot(r, 7'(8'h40 + r), 1'b1, 8'(r), 5'd1, 8'h00);
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_rsp();
            check($sformatf("fair_gnt_%0d", i), 32'(r_gnt), 32'(3'b001 << (i % 3)));
        end
        req = '0;

        // Watchdog timeout on requester 1, then normal service
        hang_mode = 1'b1;
        set_slot(1, 7'h55, 1'b0, 8'h01, 5'd1, 8'h00);
        base = arst_lo;
        req[1] = 1'b1;
        wait_rsp();
        req[1] = 1'b0;
        hang_mode = 1'b0;
        check("tmo_gnt", 32'(r_gnt), 32'(3'b010));
        check("tmo_flag", 32'(r_tmo), 32'(1));
        check("tmo_nack", 32'(r_nack), 32'(1));
        check("tmo_rddata", 32'(r_data), 32'(0));
        check("tmo_arst_cycles", 32'(arst_lo - base), 32'(2));
        set_slot(2, 7'h12, 1'b1, 8'h05, 5'd3, 8'h00);
        req[2] = 1'b1;
        wait_rsp();
        req[2] = 1'b0;
        check("post_tmo_gnt", 32'(r_gnt), 32'(3'b100));
        check("post_tmo_flag", 32'(r_tmo), 32'(0));
        check("post_tmo_rddata", 32'(r_data), 32'(8'h3C));

        // Move ptr off zero, then reset in the middle of a transaction
        req[0] = 1'b1;
        wait_rsp();
        req[0] = 1'b0;
        req[1] = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_gnt_before", 32'(gnt), 32'(3'b010));
        base = rsp_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        check("mid_rst_gnt", 32'(gnt), 32'(0));
        check("mid_rst_enable", 32'(i2c_enable), 32'(0));
        check("mid_rst_arst_n", 32'(ctrl_arst_n), 32'(1));
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        repeat (60) @(negedge clk);
        check("mid_rst_no_rsp", 32'(rsp_count - base), 32'(0));
        req = 3'b111;
        @(negedge clk);
        check("mid_rst_ptr", 32'(gnt), 32'(3'b001));
        wait_rsp();
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
